// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - captures ALU result words and streams them LSB-byte first
// Active word in a right-shift register; one pending slot absorbs a word arriving mid-send.
module alu_result_serializer #(
  parameter int Width = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] ALU_OUT,
  input  logic             OUT_VALID,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic             BUSY,
  output logic             OVERFLOW
);

  localparam int BYTES = Width / 8;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       state;
  logic             valid_d;
  logic [Width-1:0] active;
  logic [CW-1:0]    cnt;
  logic [Width-1:0] pend;
  logic             pend_valid;
  logic             ovf;

  logic capture;
  logic xfer;
  logic last;

  assign capture = OUT_VALID & ~valid_d;
  assign xfer    = (state == ST_SEND) & TX_READY;
  assign last    = (cnt == LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      valid_d    <= 1'b0;
      active     <= '0;
      cnt        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      valid_d <= OUT_VALID;
      ovf     <= 1'b0;
      if (state == ST_IDLE) begin
        if (capture) begin
          active <= ALU_OUT;
          cnt    <= '0;
          state  <= ST_SEND;
        end
      end else if (xfer && last) begin
        // Word boundary: refill from pending first so the new capture can take its slot.
        if (pend_valid) begin
          active <= pend;
          cnt    <= '0;
          if (capture) begin
            pend <= ALU_OUT;
          end else begin
            pend_valid <= 1'b0;
          end
        end else if (capture) begin
          active <= ALU_OUT;
          cnt    <= '0;
        end else begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      end else begin
        if (xfer) begin
          active <= active >> 8;
          cnt    <= cnt + 1'b1;
        end
        if (capture) begin
          if (!pend_valid) begin
            pend       <= ALU_OUT;
            pend_valid <= 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end
      end
    end
  end

  assign TX_VALID = (state == ST_SEND);
  assign TX_DATA  = (state == ST_SEND) ? active[7:0] : 8'h00;
  assign BUSY     = (state == ST_SEND) | pend_valid;
  assign OVERFLOW = ovf;

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb/tb_alu_result_serializer.sv - directed bench for alu_result_serializer
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_result_serializer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;
  logic        OVERFLOW;

  int tests = 0;
  int fails = 0;

  alu_result_serializer #(.Width(16)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0; ALU_OUT = 16'h0; OUT_VALID = 1'b0; TX_READY = 1'b0;
    step(); step();
    tests++;
    if (TX_DATA !== 8'h00 || TX_VALID !== 1'b0 || BUSY !== 1'b0 || OVERFLOW !== 1'b0) begin
      fails++;
      $display("FAIL reset: data=%h valid=%b busy=%b ovf=%b expected 00 0 0 0", TX_DATA, TX_VALID, BUSY, OVERFLOW);
    end
    RST = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    logic [7:0] exp [2] = '{8'hC3, 8'hA5};
    ALU_OUT = 16'hA5C3; OUT_VALID = 1'b1; TX_READY = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin
        fails++;
        $display("FAIL single_byte%0d: valid=%b data=%h expected 1 %h", i, TX_VALID, TX_DATA, exp[i]);
      end
      step();
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || TX_DATA !== 8'h00) begin
        fails++;
        $display("FAIL single_idle%0d: valid=%b busy=%b data=%h expected 0 0 00", i, TX_VALID, BUSY, TX_DATA);
      end
      step();
    end
    OUT_VALID = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    ALU_OUT = 16'h1234; OUT_VALID = 1'b1; TX_READY = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (TX_VALID !== 1'b1 || TX_DATA !== 8'h34) begin
        fails++;
        $display("FAIL bp_stall%0d: valid=%b data=%h expected 1 34", i, TX_VALID, TX_DATA);
      end
      step();
    end
    TX_READY = 1'b1;
    tests++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'h34) begin
      fails++;
      $display("FAIL bp_release: valid=%b data=%h expected 1 34", TX_VALID, TX_DATA);
    end
    step();
    tests++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'h12) begin
      fails++;
      $display("FAIL bp_byte1: valid=%b data=%h expected 1 12", TX_VALID, TX_DATA);
    end
    step();
    tests++;
    if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL bp_idle: valid=%b busy=%b expected 0 0", TX_VALID, BUSY);
    end
    OUT_VALID = 1'b0;
    step();
  endtask

  task automatic test_pending();
    logic [7:0] exp [4] = '{8'h11, 8'h11, 8'h22, 8'h22};
    TX_READY = 1'b0;
    ALU_OUT = 16'h1111; OUT_VALID = 1'b1; step();
    OUT_VALID = 1'b0; step();
    ALU_OUT = 16'h2222; OUT_VALID = 1'b1; step();
    OUT_VALID = 1'b0;
    tests++;
    if (BUSY !== 1'b1 || TX_DATA !== 8'h11 || OVERFLOW !== 1'b0) begin
      fails++;
      $display("FAIL pend_stall: busy=%b data=%h ovf=%b expected 1 11 0", BUSY, TX_DATA, OVERFLOW);
    end
    TX_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (TX_VALID !== 1'b1 || TX_DATA !== exp[i] || OVERFLOW !== 1'b0) begin
        fails++;
        $display("FAIL pend_byte%0d: valid=%b data=%h ovf=%b expected 1 %h 0", i, TX_VALID, TX_DATA, OVERFLOW, exp[i]);
      end
      step();
    end
    tests++;
    if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL pend_idle: valid=%b busy=%b expected 0 0", TX_VALID, BUSY);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [4] = '{8'hAA, 8'hAA, 8'hBB, 8'hBB};
    TX_READY = 1'b0;
    ALU_OUT = 16'hAAAA; OUT_VALID = 1'b1; step();
    OUT_VALID = 1'b0; step();
    ALU_OUT = 16'hBBBB; OUT_VALID = 1'b1; step();
    OUT_VALID = 1'b0; step();
    tests++;
    if (OVERFLOW !== 1'b0) begin
      fails++;
      $display("FAIL ovf_before: ovf=%b expected 0", OVERFLOW);
    end
    ALU_OUT = 16'hCCCC; OUT_VALID = 1'b1; step();
    OUT_VALID = 1'b0;
    tests++;
    if (OVERFLOW !== 1'b1) begin
      fails++;
      $display("FAIL ovf_pulse: ovf=%b expected 1", OVERFLOW);
    end
    step();
    tests++;
    if (OVERFLOW !== 1'b0) begin
      fails++;
      $display("FAIL ovf_one_cycle: ovf=%b expected 0", OVERFLOW);
    end
    TX_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin
        fails++;
        $display("FAIL ovf_byte%0d: valid=%b data=%h expected 1 %h", i, TX_VALID, TX_DATA, exp[i]);
      end
      step();
    end
    tests++;
    if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL ovf_idle: valid=%b busy=%b expected 0 0 (dropped word sent)", TX_VALID, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6] = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC};
    TX_READY = 1'b0;
    ALU_OUT = 16'hAAAA; OUT_VALID = 1'b1; step();
    OUT_VALID = 1'b0; step();
    ALU_OUT = 16'hBBBB; OUT_VALID = 1'b1; step();
    OUT_VALID = 1'b0;
    TX_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      // CCCC rises on the AAAA last-byte transfer edge while BBBB is pending
      if (i == 1) begin
        ALU_OUT = 16'hCCCC; OUT_VALID = 1'b1;
      end else begin
        OUT_VALID = 1'b0;
      end
      tests++;
      if (TX_VALID !== 1'b1 || TX_DATA !== exp[i] || OVERFLOW !== 1'b0) begin
        fails++;
        $display("FAIL b2b_byte%0d: valid=%b data=%h ovf=%b expected 1 %h 0", i, TX_VALID, TX_DATA, OVERFLOW, exp[i]);
      end
      step();
    end
    tests++;
    if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: valid=%b busy=%b expected 0 0", TX_VALID, BUSY);
    end
  endtask

  task automatic test_reset_mid_word();
    TX_READY = 1'b1;
    ALU_OUT = 16'hBEEF; OUT_VALID = 1'b1; step();
    tests++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'hEF) begin
      fails++;
      $display("FAIL rst_byte0: valid=%b data=%h expected 1 ef", TX_VALID, TX_DATA);
    end
    step();
    RST = 1'b0;
    #1;
    tests++;
    if (TX_DATA !== 8'h00 || TX_VALID !== 1'b0 || BUSY !== 1'b0 || OVERFLOW !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: data=%h valid=%b busy=%b ovf=%b expected 00 0 0 0", TX_DATA, TX_VALID, BUSY, OVERFLOW);
    end
    step();
    RST = 1'b1;
    step();
    tests++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'hEF) begin
      fails++;
      $display("FAIL rst_resend0: valid=%b data=%h expected 1 ef", TX_VALID, TX_DATA);
    end
    step();
    tests++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'hBE) begin
      fails++;
      $display("FAIL rst_resend1: valid=%b data=%h expected 1 be", TX_VALID, TX_DATA);
    end
    step();
    tests++;
    if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL rst_idle: valid=%b busy=%b expected 0 0", TX_VALID, BUSY);
    end
    OUT_VALID = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_pending();
    test_overflow();
    test_back_to_back();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
